// File: rtl/gpu_wb_cmd_queue.sv
// GPU Wishbone write-command queue.
// Buffers write commands and replays them as single Wishbone writes.
module gpu_wb_cmd_queue #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [26:0]                i_adr,
   input  logic [31:0]                i_dat,
   input  logic [3:0]                 i_sel,
   input  logic                       i_clear_err,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_busy,
   output logic                       o_overflow,
   output logic                       o_timeout_err,
   output logic                       wb_cyc_o,
   output logic                       wb_stb_o,
   output logic                       wb_we_o,
   output logic [26:0]                wb_adr_o,
   output logic [31:0]                wb_dat_o,
   output logic [3:0]                 wb_sel_o,
   input  logic                       wb_ack_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   level;
   logic [15:0]     wait_cnt;
   logic [62:0]     mem [DEPTH];
   logic [62:0]     head;
   logic            push_ok;
   logic            load;
   logic            pop;
   logic            abort;

   assign o_level = level;
   assign o_full  = (level == FULL_LVL);
   assign o_busy  = (level != '0) | (state_q != IDLE);
   assign push_ok = i_push & ~o_full & ~reset;
   assign head    = mem[rd_ptr];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state; ack wins over a timeout landing on the same cycle.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      pop     = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (level != '0) begin
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (wb_ack_i) begin
               pop     = 1'b1;
               state_d = GAP;
            end else if (wait_cnt == TO_LAST) begin
               pop     = 1'b1;
               abort   = 1'b1;
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {i_adr, i_dat, i_sel};
   end

   // Wishbone master outputs and ack wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
         wait_cnt <= '0;
      end else if (load) begin
         wb_cyc_o <= 1'b1;
         wb_stb_o <= 1'b1;
         wb_we_o  <= 1'b1;
         wb_adr_o <= head[62:36];
         wb_dat_o <= head[35:4];
         wb_sel_o <= head[3:0];
         wait_cnt <= '0;
      end else if (pop) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wait_cnt <= '0;
      end else if (state_q == ISSUE) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // Sticky error flags; a new event beats a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_overflow    <= 1'b0;
         o_timeout_err <= 1'b0;
      end else begin
         o_overflow    <= (i_push & o_full) |
                          (o_overflow & ~i_clear_err);
         o_timeout_err <= abort |
                          (o_timeout_err & ~i_clear_err);
      end
   end

endmodule
